// File: rtl/temp_conv_pkg.sv
// +----------------------------------------------------------------------+
// | temp_conv_pkg                                                        |
// | Shared constants and FSM state type for the temperature converters.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package temp_conv_pkg;

  localparam int unsigned F_OFFSET   = 32;
  localparam int unsigned SCALE_NUM  = 5;
  localparam int unsigned SCALE_DEN  = 9;
  localparam int unsigned ROUND_BIAS = 4;
  localparam int unsigned F_MAX      = 212;
  localparam int unsigned DIV_STEPS  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } f2c_state_t;

endpackage

`default_nettype wire

// File: rtl/f2c_converter_if.sv
// +----------------------------------------------------------------------+
// | f2c_converter_if                                                     |
// | Input and output valid/ready channels of the F-to-C converter.       |
// | err exists only when F2C_RANGE_CHECK_EN is defined.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface f2c_converter_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] fahrenheit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] celsius;
`ifdef F2C_RANGE_CHECK_EN
  logic       err;

  modport master (
    output in_valid, fahrenheit, out_ready,
    input  in_ready, out_valid, celsius, err
  );

  modport slave (
    input  in_valid, fahrenheit, out_ready,
    output in_ready, out_valid, celsius, err
  );
`else
  modport master (
    output in_valid, fahrenheit, out_ready,
    input  in_ready, out_valid, celsius
  );

  modport slave (
    input  in_valid, fahrenheit, out_ready,
    output in_ready, out_valid, celsius
  );
`endif

endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------+
// | seq_divider                                                          |
// | Restoring divider, 11-bit dividend / 4-bit divisor, 1 bit per cycle. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import temp_conv_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [10:0] dividend,
  input  wire logic [3:0]  divisor,
  output logic             done,
  output logic [10:0]      quotient
);

  localparam logic [DIV_STEPS-1:0] c_cnt_load = {1'b1, {(DIV_STEPS-1){1'b0}}};

  logic [DIV_STEPS-1:0] r_cnt;
  logic [10:0]          r_work;
  logic [3:0]           r_rem;
  logic [3:0]           r_divisor;

  logic [4:0]  w_trial;
  logic [4:0]  w_diff;
  logic        w_ge;
  logic [3:0]  w_rem_nxt;
  logic [10:0] w_work_nxt;

  // r_work shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    w_trial    = {r_rem, r_work[10]};
    w_ge       = (w_trial >= {1'b0, r_divisor});
    w_diff     = w_trial - {1'b0, r_divisor};
    w_rem_nxt  = 4'(w_ge ? w_diff : w_trial);
    w_work_nxt = {r_work[9:0], w_ge};
  end

  // done marks the cycle whose step is the last; quotient is that step's result
  assign done     = r_cnt[0];
  assign quotient = w_work_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (start) begin
      r_cnt     <= c_cnt_load;
      r_work    <= dividend;
      r_rem     <= '0;
      r_divisor <= divisor;
    end else if (|r_cnt) begin
      r_cnt     <= r_cnt >> 1;
      r_work    <= w_work_nxt;
      r_rem     <= w_rem_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/f2c_converter.sv
// +----------------------------------------------------------------------+
// | f2c_converter                                                        |
// | Sequential round((F-32)*5/9) converter with valid/ready channels.    |
// | Optional err output: define F2C_RANGE_CHECK_EN.                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module f2c_converter
  import temp_conv_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst_n,
  f2c_converter_if.slave bus
);

  f2c_state_t r_state;
  f2c_state_t w_state_nxt;

  logic [7:0]  r_fahr;
  logic        r_sign;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [7:0]  r_celsius;

  logic        w_div_start;
  logic        w_div_done;
  logic [10:0] w_quotient;
  logic [8:0]  w_diff;
  logic [8:0]  w_mag;
  logic [10:0] w_scaled;

  // |F-32|*5 + bias as shift-add; the bias gives round-to-nearest after /9
  always_comb begin
    w_diff   = {1'b0, r_fahr} - 9'(F_OFFSET);
    w_mag    = w_diff[8] ? (9'd0 - w_diff) : w_diff;
    w_scaled = {w_mag, 2'b00} + 11'(w_mag) + 11'(ROUND_BIAS);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = SCALE;
      SCALE: begin
        w_div_start = 1'b1;
        w_state_nxt = DIV;
      end
      DIV:     if (w_div_done) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_celsius   <= '0;
      r_fahr      <= '0;
      r_sign      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (r_state == IDLE && bus.in_valid)
        r_fahr <= bus.fahrenheit;
      if (r_state == SCALE)
        r_sign <= w_diff[8];
      // sign is restored on the magnitude so rounding is symmetric about zero
      if (r_state == DIV && w_div_done)
        r_celsius <= 8'(r_sign ? (11'd0 - w_quotient) : w_quotient);
    end
  end

  seq_divider u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_scaled),
    .divisor  (4'(SCALE_DEN)),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.celsius   = r_celsius;

`ifdef F2C_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (r_state == IDLE && bus.in_valid)
      r_err <= (bus.fahrenheit > 8'(F_MAX));
    else if (r_state == DONE && bus.out_ready)
      r_err <= 1'b0;
  end

  assign bus.err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_f2c_converter.sv
// +----------------------------------------------------------------------+
// | tb_f2c_converter                                                     |
// | Self-checking bench for f2c_converter against a real-valued model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_f2c_converter;

  localparam int NOLIT = 1000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  f2c_converter_if bus ();

  f2c_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit exp_e[$];
  bit prev_hold = 1'b0;

  // Celsius rounded to nearest, halves (never reached) away from zero
  function automatic int model(input int f);
    real c;
    real r;
    c = real'(f - 32) * 5.0 / 9.0;
    if (c < 0.0) r = -$floor(-c + 0.5);
    else         r = $floor(c + 0.5);
    return $rtoi(r);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !bus.out_valid) check("hold_dropped", 0, 1);
      if (bus.in_ready && bus.out_valid) check("ready_valid_overlap", 1, 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("celsius", int'($signed(bus.celsius)), exp_q[0]);
`ifdef F2C_RANGE_CHECK_EN
          check("err", int'(bus.err), int'(exp_e[0]));
`endif
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_e.pop_front());
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  task automatic convert(input int f, input int hold, input bit stray, input int lit);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.fahrenheit = 8'(f);
    bus.in_valid   = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(f));
    exp_e.push_back(f > 212);
    #1;
    bus.in_valid   = 1'b0;
    bus.fahrenheit = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      bus.in_valid  = stray && (n == 5);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (!bus.out_valid) check("in_ready_busy", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("latency", n, 12);
    if (lit != NOLIT) check("celsius_literal", int'($signed(bus.celsius)), lit);
`ifdef F2C_RANGE_CHECK_EN
    check("err_at_done", int'(bus.err), int'(f > 212));
`endif
    repeat (hold) begin
      @(posedge clk); #1;
      check("in_ready_hold", int'(bus.in_ready), 0);
      check("out_valid_hold", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_hs", int'(bus.in_ready), 1);
    check("out_valid_after_hs", int'(bus.out_valid), 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_celsius", int'(bus.celsius), 0);
`ifdef F2C_RANGE_CHECK_EN
    check("rst_err", int'(bus.err), 0);
`endif
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.fahrenheit = 8'd0;
    bus.out_ready  = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    check("model_212", model(212), 100);
    check("model_0", model(0), -18);
    check("model_31", model(31), -1);
    check("model_98", model(98), 37);
    check("model_255", model(255), 124);
    check("model_213", model(213), 101);

    convert(212, 0, 1'b0, 100);
    convert(32,  0, 1'b0, 0);
    convert(0,   0, 1'b0, -18);
    convert(31,  0, 1'b0, -1);
    convert(98,  0, 1'b0, 37);
    convert(255, 0, 1'b0, 124);
    convert(150, 20, 1'b1, 66);
`ifdef F2C_RANGE_CHECK_EN
    convert(213, 0, 1'b0, 101);
    convert(212, 0, 1'b0, 100);
`endif

    // abort a conversion mid-divide
    bus.fahrenheit = 8'd100;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_e.delete();
    #1;
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("no_out_after_abort", int'(bus.out_valid), 0);
    end
    convert(50, 0, 1'b0, 10);

    for (int f = 0; f < 256; f++)
      convert(f, $urandom_range(0, 3), 1'b0, NOLIT);
    repeat (50)
      convert($urandom_range(0, 255), $urandom_range(0, 5), 1'($urandom_range(0, 1)), NOLIT);

    repeat (3) @(posedge clk);
    #1;
    check("results_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
